// File: rtl/uart_tx_engine_if.sv
// Write port of the UART transmit engine: byte data with a valid/ready
// handshake. The producer (register block) uses the master modport; the
// engine's TX FIFO uses the slave modport.
//   tx_data        8  write data, bit 0 is sent first
//   tx_data_valid  1  write request
//   tx_data_ready  1  FIFO has room; a write is taken when valid && ready
interface uart_tx_engine_if;
    logic [7:0] tx_data;
    logic       tx_data_valid;
    logic       tx_data_ready;

    modport master (
        output tx_data,
        output tx_data_valid,
        input  tx_data_ready
    );

    modport slave (
        input  tx_data,
        input  tx_data_valid,
        output tx_data_ready
    );
endinterface

// File: rtl/uart_tx_engine.sv
// UART transmit engine with a small TX FIFO and a runtime frame format
// (5..8 data bits, none/even/odd parity, 1 or 2 stop bits). Bit timing comes
// from an external baud tick; every bit lasts OVERSAMPLE ticks.
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   sck_rising_edge   single-cycle baud tick
//   wr                write port (uart_tx_engine_if.slave)
//   cfg_*             frame format, latched at every frame start
//   sout              registered serial output, idle high
//   busy              FSM active or FIFO holding data
//   fifo_level        occupied FIFO entries
//
// state    | meaning
// ---------+-----------------------------------------------
// S_IDLE   | line idle, waiting for a FIFO entry
// S_START  | driving the start bit
// S_DATA   | shifting out data bits, LSB first
// S_PARITY | driving the parity bit
// S_STOP   | driving one or two stop bits
module uart_tx_engine #(
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             sck_rising_edge,
    uart_tx_engine_if.slave                  wr,
    input  logic [1:0]                       cfg_data_bits,
    input  logic                             cfg_parity_en,
    input  logic                             cfg_parity_odd,
    input  logic                             cfg_stop2,
    output logic                             sout,
    output logic                             busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t        state, state_nxt;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          fifo_empty, push, pop;
    logic [7:0]    head, dmask;

    logic [TW-1:0] tick_cnt, tick_cnt_nxt;
    logic [2:0]    bit_cnt, bit_cnt_nxt;
    logic          stop_cnt, stop_cnt_nxt;
    logic [7:0]    shreg, shreg_nxt;
    logic          par_bit, par_bit_nxt;
    logic [1:0]    f_dbits, f_dbits_nxt;
    logic          f_par_en, f_par_en_nxt;
    logic          f_stop2, f_stop2_nxt;
    logic          sout_nxt;
    logic          bit_end, start_frame;
    logic [2:0]    last_bit;

    assign fifo_empty       = (fifo_level == '0);
    assign wr.tx_data_ready = (fifo_level != LVL_FULL);
    assign push             = wr.tx_data_valid && wr.tx_data_ready;
    assign head             = mem[rd_ptr];
    // Parity only covers the bits actually sent, so mask with the live
    // config that is being latched in the same cycle.
    assign dmask            = 8'hFF >> (2'd3 - cfg_data_bits);
    assign last_bit         = 3'd4 + {1'b0, f_dbits};
    assign busy             = (state != S_IDLE) || !fifo_empty;

    always_comb begin
        state_nxt    = state;
        tick_cnt_nxt = tick_cnt;
        bit_cnt_nxt  = bit_cnt;
        stop_cnt_nxt = stop_cnt;
        shreg_nxt    = shreg;
        par_bit_nxt  = par_bit;
        f_dbits_nxt  = f_dbits;
        f_par_en_nxt = f_par_en;
        f_stop2_nxt  = f_stop2;
        sout_nxt     = sout;
        pop          = 1'b0;
        bit_end      = 1'b0;
        start_frame  = 1'b0;

        // Ticks are ignored in IDLE, so a tick in the frame-start cycle
        // does not eat into the start bit.
        if (state != S_IDLE && sck_rising_edge) begin
            if (tick_cnt == TICK_LAST) begin
                tick_cnt_nxt = '0;
                bit_end      = 1'b1;
            end else begin
                tick_cnt_nxt = tick_cnt + 1'b1;
            end
        end

        case (state)
            S_IDLE: begin
                sout_nxt = 1'b1;
                if (!fifo_empty) start_frame = 1'b1;
            end
            S_START: begin
                if (bit_end) begin
                    state_nxt   = S_DATA;
                    bit_cnt_nxt = '0;
                    sout_nxt    = shreg[0];
                    shreg_nxt   = {1'b0, shreg[7:1]};
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_cnt == last_bit) begin
                        if (f_par_en) begin
                            state_nxt = S_PARITY;
                            sout_nxt  = par_bit;
                        end else begin
                            state_nxt    = S_STOP;
                            sout_nxt     = 1'b1;
                            stop_cnt_nxt = 1'b0;
                        end
                    end else begin
                        sout_nxt    = shreg[0];
                        shreg_nxt   = {1'b0, shreg[7:1]};
                        bit_cnt_nxt = bit_cnt + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_nxt    = S_STOP;
                    sout_nxt     = 1'b1;
                    stop_cnt_nxt = 1'b0;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (stop_cnt == f_stop2) begin
                        // Chain straight into the next frame when data waits.
                        if (!fifo_empty) start_frame = 1'b1;
                        else             state_nxt   = S_IDLE;
                    end else begin
                        stop_cnt_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        if (start_frame) begin
            pop          = 1'b1;
            state_nxt    = S_START;
            sout_nxt     = 1'b0;
            shreg_nxt    = head;
            f_dbits_nxt  = cfg_data_bits;
            f_par_en_nxt = cfg_parity_en;
            f_stop2_nxt  = cfg_stop2;
            par_bit_nxt  = (^(head & dmask)) ^ cfg_parity_odd;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr.tx_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            f_dbits    <= '0;
            f_par_en   <= 1'b0;
            f_stop2    <= 1'b0;
            sout       <= 1'b1;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            state    <= state_nxt;
            tick_cnt <= tick_cnt_nxt;
            bit_cnt  <= bit_cnt_nxt;
            stop_cnt <= stop_cnt_nxt;
            shreg    <= shreg_nxt;
            par_bit  <= par_bit_nxt;
            f_dbits  <= f_dbits_nxt;
            f_par_en <= f_par_en_nxt;
            f_stop2  <= f_stop2_nxt;
            sout     <= sout_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end
endmodule
